ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 256: watchdog limit in cycles, used only when RAM_ARB_TIMEOUT_EN is defined.
REQ-002 CLK  in  1: single clock; all state SHALL update on the rising edge.
REQ-003 RST  in  1: reset, synchronous, active-high.
REQ-004 iren  in  1 / iaddr  in  32: instruction-fetch read request and word address.
REQ-005 iload  out  32 / iready  out  1 / ierror  out  1: fetch data, completion pulse, error pulse.
REQ-006 dren  in  1 / dwen  in  1 / daddr  in  32 / dstore  in  32: data-port read, write, address and write data.
REQ-007 dload  out  32 / dready  out  1 / derror  out  1: data-port load data, completion pulse, error pulse.
REQ-008 ram_addr  out  32 / ram_store  out  32 / ram_ren  out  1 / ram_wen  out  1: shared RAM request.
REQ-009 ram_load  in  32 / ram_state  in  2 (ram_state_t): RAM read data and status (FREE, BUSY, DONE, ERROR).

Function
REQ-010 FSM states IDLE, IGRANT, DGRANT, registered; all RAM outputs SHALL be driven from registered state and latched request fields.
REQ-011 IDLE: data request pending and (rr_last==INST or no fetch pending) -> DGRANT; fetch pending -> IGRANT; else stay.
REQ-012 Round-robin: rr_last SHALL record the last requester that completed; on a tie the other requester wins.
REQ-013 On grant, address, store data and read/write kind SHALL be latched; ram_ren/ram_wen SHALL assert from the cycle after the request is first seen.
REQ-014 dren and dwen both high: treated as a write; ram_ren SHALL stay 0.
REQ-015 Granted and ram_state==DONE: granted requester's ready SHALL pulse high for exactly that cycle, and its load output SHALL equal ram_load (combinational).
REQ-016 Granted and ram_state==ERROR: granted requester's error SHALL pulse for that cycle; ready stays 0.
REQ-017 On DONE or ERROR, next state SHALL be chosen by the IDLE rules (REQ-011) in the same cycle, allowing back-to-back grants with no idle bubble.
REQ-018 Granted requester dropping its request before DONE/ERROR: abort; strobes SHALL drop next cycle, state -> IDLE, no ready or error pulse.
REQ-019 Minimum latency: request at cycle N, strobe at N+1, ready at N+1 if RAM answers DONE immediately.
REQ-020 Non-granted requester's ready/error SHALL stay 0; its load output SHALL be 0.
REQ-021 ram_state FREE/BUSY while granted: hold all strobes and latched fields unchanged.

Reset
REQ-022 RST high: state IDLE, rr_last=DATA, ram_ren=ram_wen=0, ram_addr=ram_store=0, all ready/error 0, watchdog 0.
REQ-023 RST mid-access: the access SHALL be abandoned with no ready/error pulse; strobes SHALL be 0 in the first cycle after reset.

Configuration
REQ-024 Macro RAM_ARB_TIMEOUT_EN defined: a counter SHALL count granted cycles without DONE/ERROR; on reaching TIMEOUT_CYCLES it SHALL pulse the granted requester's error, drop the strobes and go IDLE.
REQ-025 RAM_ARB_TIMEOUT_EN undefined: no counter logic; an access SHALL wait indefinitely.

Structure
REQ-026 ram_state_t (FREE=0, BUSY=1, DONE=2, ERROR=3), arb_state_t and requester-id enum SHALL live in rv32ima_pkg; word_t SHALL come from the same package.
REQ-027 One sub-module, ram_arb_watchdog (counter plus compare), instantiated only under RAM_ARB_TIMEOUT_EN.

Verification
REQ-028 Fetch only: iren=1, iaddr=0x100, RAM DONE after 2 BUSY cycles with ram_load=0x00000013 -> ram_ren=1 and ram_addr=0x100 for 3 cycles, iready single pulse, iload=0x13.
REQ-029 Simultaneous: iren and dwen high after reset (rr_last=DATA) -> IGRANT first; then DGRANT with ram_wen=1 and ram_store=dstore, with no idle cycle between grants.
REQ-030 Continuous contention for 8 accesses -> grants strictly alternate I,D,I,D...
REQ-031 ram_state=ERROR during DGRANT read -> derror pulse for 1 cycle, dready=0, next grant proceeds.
REQ-032 RST asserted on the 2nd BUSY cycle -> next cycle ram_ren=0, no ready pulse; dren/dwen held -> new grant after reset.
REQ-033 RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, RAM stuck BUSY -> error pulse on the 4th granted cycle, strobes 0 on the next cycle.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types for the RAM arbiter: word type, RAM status,
// arbiter FSM states and requester ids.
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } ram_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_arb_watchdog.sv
// Counts granted cycles without a RAM answer and flags expiry
// on the LIMIT-th such cycle.
module ram_arb_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || !active) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = active && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between fetch and data.
// Optional watchdog enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_arbiter
  import rv32ima_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iren,
  input  word_t      iaddr,
  output word_t      iload,
  output logic       iready,
  output logic       ierror,
  input  logic       dren,
  input  logic       dwen,
  input  word_t      daddr,
  input  word_t      dstore,
  output word_t      dload,
  output logic       dready,
  output logic       derror,
  output word_t      ram_addr,
  output word_t      ram_store,
  output logic       ram_ren,
  output logic       ram_wen,
  input  word_t      ram_load,
  input  ram_state_t ram_state
);

  arb_state_t state, state_n;
  req_id_t    rr_last, rr_n;
  word_t      addr_n, store_n;
  logic       ren_n, wen_n;
  logic       arb, dpend, fin, expired;

  assign dpend = dren | dwen;
  assign fin   = (ram_state == DONE) || (ram_state == ERROR);

`ifdef RAM_ARB_TIMEOUT_EN
  ram_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .CLK    (CLK),
    .RST    (RST),
    .active ((state != IDLE) && !fin),
    .expired(expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rr_last   <= DATA;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_last   <= rr_n;
      ram_addr  <= addr_n;
      ram_store <= store_n;
      ram_ren   <= ren_n;
      ram_wen   <= wen_n;
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_last;
    addr_n  = ram_addr;
    store_n = ram_store;
    ren_n   = ram_ren;
    wen_n   = ram_wen;
    iload   = '0;
    dload   = '0;
    iready  = 1'b0;
    ierror  = 1'b0;
    dready  = 1'b0;
    derror  = 1'b0;
    arb     = 1'b0;
    unique case (state)
      IDLE: arb = 1'b1;
      IGRANT: begin
        if (ram_state == DONE) begin
          iready = 1'b1;
          iload  = ram_load;
          rr_n   = INST;
          arb    = 1'b1;
        end else if (ram_state == ERROR) begin
          ierror = 1'b1;
          rr_n   = INST;
          arb    = 1'b1;
        end else if (expired) begin
          ierror  = 1'b1;
          rr_n    = INST;
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else if (!iren) begin
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end
      end
      DGRANT: begin
        if (ram_state == DONE) begin
          dready = 1'b1;
          dload  = ram_load;
          rr_n   = DATA;
          arb    = 1'b1;
        end else if (ram_state == ERROR) begin
          derror = 1'b1;
          rr_n   = DATA;
          arb    = 1'b1;
        end else if (expired) begin
          derror  = 1'b1;
          rr_n    = DATA;
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else if (!dpend) begin
          state_n = IDLE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // rr_n already reflects a completion in this cycle
    if (arb) begin
      if (dpend && (rr_n == INST || !iren)) begin
        state_n = DGRANT;
        addr_n  = daddr;
        store_n = dstore;
        ren_n   = ~dwen;
        wen_n   = dwen;
      end else if (iren) begin
        state_n = IGRANT;
        addr_n  = iaddr;
        store_n = '0;
        ren_n   = 1'b1;
        wen_n   = 1'b0;
      end else begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests, a simple RAM
// responder model and a monitor that checks every ready/error pulse.
module tb_ram_arbiter;
  import rv32ima_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       iren = 1'b0;
  word_t      iaddr = '0;
  word_t      iload;
  logic       iready, ierror;
  logic       dren = 1'b0;
  logic       dwen = 1'b0;
  word_t      daddr = '0;
  word_t      dstore = '0;
  word_t      dload;
  logic       dready, derror;
  word_t      ram_addr, ram_store;
  logic       ram_ren, ram_wen;
  word_t      ram_load = '0;
  ram_state_t ram_state = FREE;

  always #5 CLK = ~CLK;

  ram_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .iren(iren), .iaddr(iaddr), .iload(iload),
    .iready(iready), .ierror(ierror),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dready(dready), .derror(derror),
    .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_load(ram_load), .ram_state(ram_state)
  );

  typedef struct {
    bit    port;
    bit    err;
    word_t addr;
    bit    wen;
    word_t store;
    word_t load;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  bit   stuck = 1'b0;
  int   ren_cycles = 0;
  int   cyc = 0;
  int   rcnt = 0;
  bit   prev_act = 1'b0;
  bit   prev_fin = 1'b0;

  function automatic word_t ram_data(input word_t a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic bit is_err(input word_t a);
    return (a == 32'h300) || (a == 32'h304);
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit port, input bit err, input word_t a,
                             input bit wen, input word_t st);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.addr  = a;
    e.wen   = wen;
    e.store = st;
    e.load  = ram_data(a);
    sb.push_back(e);
  endtask

  task automatic fetch(input word_t a, output int n);
    bit got;
    iren  = 1'b1;
    iaddr = a;
    n     = 0;
    got   = 1'b0;
    while (!got && n < 64) begin
      @(posedge CLK);
      #2;
      n++;
      got = iready | ierror;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fetch_wait: addr %h got no response expected one", a);
    end
  endtask

  task automatic dreq(input word_t a, input bit rd, input bit wr,
                      input word_t st, output int n);
    bit got;
    dren   = rd;
    dwen   = wr;
    daddr  = a;
    dstore = st;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 64) begin
      @(posedge CLK);
      #2;
      n++;
      got = dready | derror;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL data_wait: addr %h got no response expected one", a);
    end
  endtask

  // RAM responder: answers lat cycles after an access starts
  initial forever begin
    @(posedge CLK);
    #1;
    if (!(ram_ren || ram_wen)) begin
      rcnt      = 0;
      ram_state = FREE;
      prev_act  = 1'b0;
      prev_fin  = 1'b0;
    end else begin
      if (!prev_act || prev_fin) rcnt = 0;
      else rcnt++;
      if (!stuck && rcnt >= lat)
        ram_state = is_err(ram_addr) ? ERROR : DONE;
      else
        ram_state = BUSY;
      prev_act = 1'b1;
      prev_fin = (ram_state == DONE) || (ram_state == ERROR);
    end
    ram_load = ram_data(ram_addr);
  end

  initial forever begin
    @(negedge CLK);
    cyc++;
    if (ram_ren) ren_cycles++;
    if (iready || ierror || dready || derror) begin
      exp_t e;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: flags %b%b%b%b expected none",
                 iready, ierror, dready, derror);
      end else begin
        e = sb.pop_front();
        chk("resp_flags", {28'd0, iready, ierror, dready, derror},
            e.port ? {30'd0, !e.err, e.err} : {28'd0, !e.err, e.err, 2'b00});
        chk("ram_addr", ram_addr, e.addr);
        chk("ram_wen", {31'd0, ram_wen}, {31'd0, e.wen});
        chk("ram_ren", {31'd0, ram_ren}, {31'd0, !e.wen});
        if (e.wen) chk("ram_store", ram_store, e.store);
        if (!e.err) chk(e.port ? "dload" : "iload", e.port ? dload : iload, e.load);
        chk("other_load", e.port ? iload : dload, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_ren", {31'd0, ram_ren}, 32'd0);
    chk("rst_wen", {31'd0, ram_wen}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_store", ram_store, 32'd0);
    chk("rst_flags", {28'd0, iready, ierror, dready, derror}, 32'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;

    lat = 2;
    ren_cycles = 0;
    expect_resp(1'b0, 1'b0, 32'h100, 1'b0, 32'd0);
    fetch(32'h100, n);
    iren = 1'b0;
    chk("fetch_latency", n, 3);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("fetch_ren_cycles", ren_cycles, 3);
    chk("fetch_ren_drop", {31'd0, ram_ren}, 32'd0);

    lat = 0;
    expect_resp(1'b0, 1'b0, 32'h104, 1'b0, 32'd0);
    fetch(32'h104, n);
    iren = 1'b0;
    chk("min_latency", n, 1);

    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    done_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      expect_resp(1'b0, 1'b0, 32'h200 + 32'(8 * k), 1'b0, 32'd0);
      expect_resp(1'b1, 1'b0, 32'h1000 + 32'(8 * k), (k % 2) == 0,
                  32'hCAFE_0000 + 32'(k));
    end
    fork
      begin
        int m;
        for (int k = 0; k < 4; k++) fetch(32'h200 + 32'(8 * k), m);
        iren = 1'b0;
      end
      begin
        int m;
        for (int k = 0; k < 4; k++)
          dreq(32'h1000 + 32'(8 * k), 1'b1, (k % 2) == 0,
               32'hCAFE_0000 + 32'(k), m);
        dren = 1'b0;
        dwen = 1'b0;
      end
    join
    @(negedge CLK);
    #1;
    chk("alt_count", done_cyc.size(), 8);
    if (done_cyc.size() == 8)
      chk("alt_no_bubble", done_cyc[7] - done_cyc[0], 7);

    expect_resp(1'b1, 1'b1, 32'h300, 1'b0, 32'd0);
    dreq(32'h300, 1'b1, 1'b0, 32'd0, n);
    dren = 1'b0;
    expect_resp(1'b0, 1'b0, 32'h400, 1'b0, 32'd0);
    fetch(32'h400, n);
    iren = 1'b0;
    chk("after_err_latency", n, 1);
    expect_resp(1'b0, 1'b1, 32'h304, 1'b0, 32'd0);
    fetch(32'h304, n);
    iren = 1'b0;

    stuck = 1'b1;
    dren  = 1'b1;
    daddr = 32'h600;
    repeat (2) @(posedge CLK);
    #2;
    dren = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("abort_ren", {31'd0, ram_ren}, 32'd0);

    dren  = 1'b1;
    daddr = 32'h700;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_mid_ren", {31'd0, ram_ren}, 32'd0);
    chk("reset_mid_flags", {28'd0, iready, ierror, dready, derror}, 32'd0);
    RST   = 1'b0;
    stuck = 1'b0;
    lat   = 0;
    expect_resp(1'b1, 1'b0, 32'h700, 1'b0, 32'd0);
    dreq(32'h700, 1'b1, 1'b0, 32'd0, n);
    dren = 1'b0;
    chk("post_reset_grant", n, 1);

`ifdef RAM_ARB_TIMEOUT_EN
    stuck = 1'b1;
    expect_resp(1'b0, 1'b1, 32'h500, 1'b0, 32'd0);
    fetch(32'h500, n);
    iren = 1'b0;
    chk("timeout_cycle", n, 4);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("timeout_ren_drop", {31'd0, ram_ren}, 32'd0);
    stuck = 1'b0;
`endif

    repeat (3) @(posedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
